// File: rtl/txrx_window_ctrl_if.sv
// Handshake bundle between the test controller, the tx/rx link and txrx_window_ctrl.
interface txrx_window_ctrl_if #(
  parameter int RW = 2
);
  logic          start;
  logic          recevier;
  logic          transmiter;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic          early_err;
  logic [RW-1:0] attempts;

  modport master (
    output start, recevier,
    input  transmiter, busy, done, pass, fail, early_err, attempts
  );

  modport slave (
    input  start, recevier,
    output transmiter, busy, done, pass, fail, early_err, attempts
  );
endinterface

// File: rtl/txrx_window_ctrl.sv
// Sequences a transmitter pulse and checks that the receiver answers inside
// [MIN_DLY:MAX_DLY] cycles, retrying up to MAX_RETRY times.
//
// state | meaning
// IDLE  | waiting for start; result flags held
// SEND  | transmiter high for this single cycle
// WAIT  | counting cycle offset k, checking recevier against the window
module txrx_window_ctrl #(
  parameter int MIN_DLY   = 2,
  parameter int MAX_DLY   = 5,
  parameter int MAX_RETRY = 3,
  parameter int CW        = 4,
  parameter int RW        = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  txrx_window_ctrl_if.slave   bus
);

  localparam logic [CW-1:0] MIN_K = CW'(MIN_DLY);
  localparam logic [CW-1:0] MAX_K = CW'(MAX_DLY);
  localparam logic [RW-1:0] MAX_A = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] attempts;
  logic          transmiter, busy, done, pass, fail, early_err;

  logic          rx_early, rx_ok, timeout, att_fail;

  always_comb begin
    rx_early = 1'b0;
    rx_ok    = 1'b0;
    timeout  = 1'b0;
    if (state == WAIT) begin
      rx_early = bus.recevier && (cnt < MIN_K);
      rx_ok    = bus.recevier && (cnt >= MIN_K) && (cnt <= MAX_K);
      timeout  = !bus.recevier && (cnt == MAX_K);
    end
    att_fail = rx_early || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      attempts   <= '0;
      transmiter <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      early_err  <= 1'b0;
    end else begin
      done       <= 1'b0;
      transmiter <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SEND;
            transmiter <= 1'b1;
            busy       <= 1'b1;
            pass       <= 1'b0;
            fail       <= 1'b0;
            early_err  <= 1'b0;
            attempts   <= '0;
            cnt        <= '0;
          end
        end
        SEND: begin
          state <= WAIT;
          cnt   <= CW'(1);
        end
        WAIT: begin
          if (rx_early)
            early_err <= 1'b1;
          if (rx_ok) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (att_fail) begin
            // a retry re-enters SEND, so the next pulse lands one cycle later
            if (attempts < MAX_A) begin
              attempts   <= attempts + 1'b1;
              transmiter <= 1'b1;
              state      <= SEND;
            end else begin
              fail  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.transmiter = transmiter;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.fail       = fail;
  assign bus.early_err  = early_err;
  assign bus.attempts   = attempts;

endmodule

// File: tb/tb_txrx_window_ctrl.sv
// Scoreboard bench for txrx_window_ctrl: stimulus queues expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_txrx_window_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  txrx_window_ctrl_if #(.RW(2)) bus ();

  txrx_window_ctrl #(
    .MIN_DLY(2), .MAX_DLY(5), .MAX_RETRY(3), .CW(4), .RW(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pass;
    bit fail;
    bit early;
    int att;
    int lat;
    int pulses;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input bit p, input bit f, input bit e, input int a,
                          input int lat, input int pulses);
    exp_t x;
    x.pass = p; x.fail = f; x.early = e; x.att = a; x.lat = lat; x.pulses = pulses;
    exp_q.push_back(x);
  endtask

  // monitor
  initial begin
    int cyc = 0;
    int t0 = 0;
    int pulses = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pulses = 0;
      end else begin
        if (bus.transmiter) begin
          if (pulses == 0) t0 = cyc;
          pulses++;
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pass", int'(bus.pass), int'(e.pass));
            check("fail", int'(bus.fail), int'(e.fail));
            check("early_err", int'(bus.early_err), int'(e.early));
            check("attempts", int'(bus.attempts), e.att);
            check("latency", cyc - t0, e.lat);
            check("tx_pulses", pulses, e.pulses);
            check("busy_at_done", int'(bus.busy), 0);
          end
          pulses = 0;
        end
      end
      cyc++;
    end
  end

  task automatic wait_tx(input string name);
    bit seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.transmiter) begin
        seen = 1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // recevier pulses land on the edge d cycles after the first transmiter edge
  task automatic rx_at(inout int cur, input int d);
    repeat (d - cur) @(negedge clk);
    bus.recevier = 1'b1;
    @(negedge clk);
    bus.recevier = 1'b0;
    cur = d + 1;
  endtask

  task automatic run_txn(input string name, input int d1, input int d2);
    int cur = 1;
    bus.start = 1'b1;
    wait_tx({name, "_tx"});
    bus.start = 1'b0;
    if (d1 > 0) rx_at(cur, d1);
    if (d2 > 0) rx_at(cur, d2);
    wait_empty({name, "_done"}, 60);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cur;
    bus.start = 1'b0;
    bus.recevier = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_transmiter", int'(bus.transmiter), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_pass", int'(bus.pass), 0);
    check("rst_fail", int'(bus.fail), 0);
    check("rst_early", int'(bus.early_err), 0);
    check("rst_attempts", int'(bus.attempts), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // k=3, k=2, k=5 all pass on the first attempt; latency k+1
    push_exp(1, 0, 0, 0, 4, 1);  run_txn("k3", 4, 0);
    push_exp(1, 0, 0, 0, 3, 1);  run_txn("k2", 3, 0);
    push_exp(1, 0, 0, 0, 6, 1);  run_txn("k5", 6, 0);
    // k=6 hits the retry SEND->WAIT edge and is ignored; retry k=3 passes
    push_exp(1, 0, 0, 1, 10, 2); run_txn("k6", 7, 10);
    // early at k=1 then k=4 on retry
    push_exp(1, 0, 1, 1, 7, 2);  run_txn("early", 2, 7);
    // recevier stuck 0: 4 pulses, 6 cycles apart, then fail
    push_exp(0, 1, 0, 3, 24, 4); run_txn("stuck", 0, 0);
    repeat (3) @(negedge clk);
    check("hold_fail", int'(bus.fail), 1);
    check("hold_attempts", int'(bus.attempts), 3);

    // reset during WAIT at k=3
    bus.start = 1'b1;
    wait_tx("rst_mid_tx");
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_transmiter", int'(bus.transmiter), 0);
    check("mid_busy", int'(bus.busy), 0);
    check("mid_done", int'(bus.done), 0);
    check("mid_pass", int'(bus.pass), 0);
    check("mid_fail", int'(bus.fail), 0);
    check("mid_early", int'(bus.early_err), 0);
    check("mid_attempts", int'(bus.attempts), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(1, 0, 0, 0, 4, 1);  run_txn("after_rst", 4, 0);

    // start pulsed while busy is ignored
    push_exp(1, 0, 0, 0, 5, 1);
    bus.start = 1'b1;
    wait_tx("busy_start_tx");
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cur = 3;
    rx_at(cur, 5);
    wait_empty("busy_start_done", 60);
    repeat (30) @(negedge clk);
    check("busy_start_idle", int'(bus.busy), 0);

    // start held across done: next transmiter one cycle after done
    push_exp(1, 0, 0, 0, 4, 1);
    push_exp(1, 0, 0, 0, 3, 1);
    bus.start = 1'b1;
    wait_tx("held_tx1");
    cur = 1;
    rx_at(cur, 4);
    check("held_done", int'(bus.done), 1);
    @(negedge clk);
    check("held_next_tx", int'(bus.transmiter), 1);
    bus.start = 1'b0;
    cur = 1;
    rx_at(cur, 3);
    wait_empty("held_done2", 60);
    repeat (10) @(negedge clk);
    check("final_idle", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
